// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and byte type
package uart_pkg;

   localparam int UART_DATA_W     = 8;
   localparam int UART_FIFO_DEPTH = 16;

   typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receiver-side and pop-side signals of the RX FIFO
interface uart_rx_fifo_if #(
   parameter int DEPTH = uart_pkg::UART_FIFO_DEPTH
);
   import uart_pkg::*;

   localparam int AW = $clog2(DEPTH);

   uart_byte_t  rx_data;
   logic        rx_rdy;
   logic        rx_rdy_clr;
   uart_byte_t  rd_data;
   logic        rd_valid;
   logic        rd_ready;
   logic [AW:0] count;
   logic        overrun;
   logic        ovr_clr;
   logic        irq;

   // Environment side: receiver and system consumer.
   modport master (
      output rx_data, rx_rdy, rd_ready, ovr_clr,
      input  rx_rdy_clr, rd_data, rd_valid, count, overrun, irq
   );

   // FIFO side.
   modport slave (
      input  rx_data, rx_rdy, rd_ready, ovr_clr,
      output rx_rdy_clr, rd_data, rd_valid, count, overrun, irq
   );

endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous circular FIFO with first-word-fall-through read
module uart_sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   // count, not the pointers, decides full/empty so the pointers can wrap freely
   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   // Storage write; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer advance and occupancy tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO with rdy/rdy_clr capture, overrun flag, optional irq (UART_RX_FIFO_IRQ_EN)
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH      = UART_FIFO_DEPTH,
   parameter int IRQ_THRESH = 8
) (
   input  logic           clk_50m,
   input  logic           rst_n,
   uart_rx_fifo_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || IRQ_THRESH < 1 || IRQ_THRESH > DEPTH) begin : g_bad_param
      $error("uart_rx_fifo: DEPTH must be a power of two >= 2 and IRQ_THRESH within 1..DEPTH");
   end

   logic        rdy_clr_q;
   logic        overrun_q;
   logic        push_evt;
   logic        drop;
   logic        fifo_full;
   logic        fifo_empty;
   logic [AW:0] fifo_count;
   uart_byte_t  fifo_head;

   // The receiver keeps rdy high through the acknowledge cycle; masking with
   // our own rdy_clr stops that same byte from being captured twice.
   assign push_evt = bus.rx_rdy && !rdy_clr_q;
   assign drop     = push_evt && fifo_full && !(bus.rd_ready && !fifo_empty);

   uart_sync_fifo #(
      .W     (UART_DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk_50m),
      .rst_n     (rst_n),
      .push      (push_evt),
      .push_data (bus.rx_data),
      .pop       (bus.rd_ready),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // One-cycle acknowledge for every captured byte, including dropped ones.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         rdy_clr_q <= 1'b0;
      end else begin
         rdy_clr_q <= push_evt;
      end
   end

   // Sticky overrun; a new drop outranks a clear in the same cycle.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         overrun_q <= 1'b0;
      end else if (drop) begin
         overrun_q <= 1'b1;
      end else if (bus.ovr_clr) begin
         overrun_q <= 1'b0;
      end
   end

   assign bus.rx_rdy_clr = rdy_clr_q;
   assign bus.rd_data    = fifo_head;
   assign bus.rd_valid   = !fifo_empty;
   assign bus.count      = fifo_count;
   assign bus.overrun    = overrun_q;

`ifdef UART_RX_FIFO_IRQ_EN
   logic [7:0] idle_cnt;
   logic       irq_q;

   // Cycles without a new byte while data waits, saturating at 255.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt <= '0;
      end else if (push_evt || fifo_empty) begin
         idle_cnt <= '0;
      end else if (idle_cnt != 8'hFF) begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end

   // Registered interrupt: fill threshold, overrun, or stale data.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= (fifo_count >= (AW+1)'(IRQ_THRESH)) || overrun_q ||
                  (!fifo_empty && (idle_cnt == 8'hFF));
      end
   end

   assign bus.irq = irq_q;
`else
   assign bus.irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
   import uart_pkg::*;

   localparam int DEPTH = 16;

   logic clk_50m = 1'b0;
   logic rst_n   = 1'b1;

   uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

   uart_rx_fifo #(
      .DEPTH      (DEPTH),
      .IRQ_THRESH (8)
   ) dut (
      .clk_50m (clk_50m),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   always #10 clk_50m = ~clk_50m;

   int checks = 0;
   int errors = 0;
   int clr_pulses = 0;
   byte unsigned drained [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a byte queue plus overrun bit and acknowledge bit.
   byte unsigned m_q [$];
   bit m_ovr = 1'b0;
   bit m_clr = 1'b0;
   bit m_evt, m_full, m_pop;

   always @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         m_ovr = 1'b0;
         m_clr = 1'b0;
      end else begin
         m_evt  = (bus.rx_rdy === 1'b1) && !m_clr;
         m_full = (m_q.size() == DEPTH);
         m_pop  = (bus.rd_ready === 1'b1) && (m_q.size() > 0);
         if (m_pop) void'(m_q.pop_front());
         if (m_evt && (!m_full || m_pop)) m_q.push_back(bus.rx_data);
         if (m_evt && m_full && !m_pop) m_ovr = 1'b1;
         else if (bus.ovr_clr === 1'b1) m_ovr = 1'b0;
         m_clr = m_evt;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk_50m) begin
      chk("rd_valid", bus.rd_valid, m_q.size() > 0);
      chk("count", bus.count, m_q.size());
      if (m_q.size() > 0) chk("rd_data", bus.rd_data, m_q[0]);
      chk("rx_rdy_clr", bus.rx_rdy_clr, m_clr);
      chk("overrun", bus.overrun, m_ovr);
`ifndef UART_RX_FIFO_IRQ_EN
      chk("irq", bus.irq, 0);
`endif
      if (bus.rx_rdy_clr === 1'b1) clr_pulses++;
      if (bus.rd_valid === 1'b1 && bus.rd_ready === 1'b1) drained.push_back(bus.rd_data);
   end

   task automatic tick();
      @(posedge clk_50m);
      #1;
   endtask

   // Receiver model: raise rdy, keep it through the ack cycle, then drop it.
   task automatic send(input byte unsigned b, input bit with_pop, input bit with_clr);
      bus.rx_data  = b;
      bus.rx_rdy   = 1'b1;
      bus.rd_ready = with_pop;
      bus.ovr_clr  = with_clr;
      tick();
      bus.rd_ready = 1'b0;
      bus.ovr_clr  = 1'b0;
      for (int i = 0; i < 4 && bus.rx_rdy_clr !== 1'b1; i++) tick();
      chk("ack_seen", bus.rx_rdy_clr, 1);
      tick();
      bus.rx_rdy = 1'b0;
   endtask

   initial begin
      int p0;
      byte unsigned exp_q [$];

      bus.rx_data  = '0;
      bus.rx_rdy   = 1'b0;
      bus.rd_ready = 1'b0;
      bus.ovr_clr  = 1'b0;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk_50m);
      #5 rst_n = 1'b1;

      chk("rst_count", bus.count, 0);
      chk("rst_rd_valid", bus.rd_valid, 0);
      chk("rst_rdy_clr", bus.rx_rdy_clr, 0);
      chk("rst_overrun", bus.overrun, 0);
      chk("rst_irq", bus.irq, 0);
      tick();

      p0 = clr_pulses;
      send(8'hA5, 1'b0, 1'b0);
      chk("single_pulses", clr_pulses - p0, 1);
      chk("single_data", bus.rd_data, 8'hA5);
      chk("single_count", bus.count, 1);
      chk("single_valid", bus.rd_valid, 1);
      bus.rd_ready = 1'b1;
      tick();
      bus.rd_ready = 1'b0;
      chk("single_pop_count", bus.count, 0);
      chk("single_pop_valid", bus.rd_valid, 0);

      bus.rd_ready = 1'b1;
      repeat (2) tick();
      bus.rd_ready = 1'b0;
      chk("empty_pop_count", bus.count, 0);

      for (int i = 0; i < 16; i++) send(byte'(i), 1'b0, 1'b0);
      chk("fill_count", bus.count, 16);
      chk("fill_overrun", bus.overrun, 0);
      p0 = clr_pulses;
      send(8'h10, 1'b0, 1'b1);
      chk("drop_pulses", clr_pulses - p0, 1);
      chk("drop_overrun", bus.overrun, 1);
      chk("drop_count", bus.count, 16);
      chk("drop_head", bus.rd_data, 8'h00);
      bus.ovr_clr = 1'b1;
      tick();
      bus.ovr_clr = 1'b0;
      chk("ovr_clr", bus.overrun, 0);

      send(8'h55, 1'b1, 1'b0);
      chk("pushpop_count", bus.count, 16);
      chk("pushpop_overrun", bus.overrun, 0);
      chk("pushpop_head", bus.rd_data, 8'h01);
      drained.delete();
      bus.rd_ready = 1'b1;
      repeat (16) tick();
      bus.rd_ready = 1'b0;
      for (int i = 1; i < 16; i++) exp_q.push_back(byte'(i));
      exp_q.push_back(8'h55);
      chk("drain_len", drained.size(), 16);
      for (int i = 0; i < 16 && i < drained.size(); i++) chk("drain_byte", drained[i], exp_q[i]);
      chk("drain_count", bus.count, 0);

      for (int i = 0; i < 4; i++) send(byte'(8'h20 + i), 1'b0, 1'b0);
      bus.rx_data = 8'h24;
      bus.rx_rdy  = 1'b1;
      tick();
      chk("pre_rst_count", bus.count, 5);
      chk("pre_rst_clr", bus.rx_rdy_clr, 1);
      #4 rst_n = 1'b0;
      bus.rx_rdy = 1'b0;
      #1;
      chk("mid_rst_valid", bus.rd_valid, 0);
      chk("mid_rst_count", bus.count, 0);
      chk("mid_rst_clr", bus.rx_rdy_clr, 0);
      @(posedge clk_50m);
      #5 rst_n = 1'b1;
      tick();
      send(8'h3C, 1'b0, 1'b0);
      chk("post_rst_data", bus.rd_data, 8'h3C);
      chk("post_rst_count", bus.count, 1);
      bus.rd_ready = 1'b1;
      tick();
      bus.rd_ready = 1'b0;
      chk("post_rst_pop", bus.count, 0);

      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Downstream consumer of the UART receiver.
- Detects each completed byte (`rdy` high), captures it into a circular FIFO and acknowledges the receiver with a one-cycle `rdy_clr` pulse.
- Presents bytes to the system side over a first-word-fall-through valid/ready pop interface.
- Tracks fill level and a sticky overrun flag, so software/CPU logic can drain the UART without per-byte polling races.

Parameters:
- DEPTH, 16, FIFO entries; power of two, min 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.
- IRQ_THRESH, 8, fill level at which `irq` asserts (optional feature only); range 1..DEPTH.

Ports:
- clk_50m  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- rx_data  input  8  byte from receiver `data`.
- rx_rdy  input  1  receiver `rdy`; high while a byte is pending.
- rx_rdy_clr  output  1  to receiver `rdy_clr`; one-cycle acknowledge pulse.
- rd_data  output  8  FIFO head byte; valid when `rd_valid`=1.
- rd_valid  output  1  FIFO non-empty.
- rd_ready  input  1  consumer pop; pop occurs when `rd_valid && rd_ready`.
- count  output  AW+1  current occupancy, 0..DEPTH.
- overrun  output  1  sticky: a byte was dropped because the FIFO was full.
- ovr_clr  input  1  clears `overrun`.
- irq  output  1  interrupt request (optional feature).

Behaviour:
- Reset (async on `rst_n` low, released synchronously to clk_50m):
  - Pointers = 0, `count` = 0, `rd_valid` = 0.
  - `rx_rdy_clr` = 0, `overrun` = 0, `irq` = 0.
  - `rd_data` is don't-care.
- Reset mid-operation discards all stored bytes. A byte pending at the receiver (`rx_rdy`=1) after reset release is captured normally.
- Capture condition: `push_evt = rx_rdy && !rx_rdy_clr`, sampled each edge.
  - On `push_evt`, assert `rx_rdy_clr` for exactly the next cycle.
  - The guard prevents double capture while the receiver's `rdy` is still high during the acknowledge cycle.
- Back-to-back bytes: if the receiver re-raises `rdy` on the same edge `rdy_clr` is consumed, `rx_rdy` stays high. The next byte is captured on the edge after `rx_rdy_clr` returns low. Minimum capture spacing is 2 cycles.
- Write: if `push_evt` and (not full, or pop in the same cycle), write `rx_data` at `wr_ptr` and increment `wr_ptr` modulo DEPTH.
- Full drop: if `push_evt` while full with no simultaneous pop:
  - Discard the byte.
  - Still pulse `rx_rdy_clr`.
  - Set `overrun`=1 on the following edge.
- Read: `rd_data` = mem[`rd_ptr`] combinationally (FWFT), so latency is 0 from storage to output. A pop increments `rd_ptr` modulo DEPTH.
- `rd_ready` while empty has no effect.
- Count update: `count` += push_accepted − pop; pointer wrap uses AW bits and `count` is authoritative for full/empty. Simultaneous push and pop:
  - Non-empty: `count` unchanged.
  - Empty: no pop occurs; push accepted; `count` becomes 1.
- Write-to-read latency: a byte captured at edge k is visible on `rd_data` with `rd_valid`=1 in cycle k+1.
- Overrun flag:
  - `ovr_clr` clears `overrun`.
  - Simultaneous `ovr_clr` and a new drop: the set wins, `overrun`=1.

Optional Feature:
- Macro: UART_RX_FIFO_IRQ_EN.
- Defined: registered `irq` = (`count` >= IRQ_THRESH) || `overrun` || (`rd_valid` && idle_timeout).
  - idle_timeout: an 8-bit counter of cycles with no `push_evt` while non-empty, saturating at 255.
  - The counter resets on push or when empty.
- Undefined: `irq` tied to 0; no timeout counter is synthesised.

Decomposition:
- Package uart_pkg:
  - UART_DATA_W = 8.
  - Default FIFO depth constant.
  - Typedef `uart_byte_t` (logic [7:0]).
- Sub-module uart_sync_fifo holds storage, pointers and `count`: synchronous push/pop with full/empty, parameterised on width/depth. It is reusable later for the TX side.
- uart_rx_fifo adds the receiver handshake, overrun and irq logic.

Test Plan:
- Single byte: `rx_rdy` raised with 0xA5 → exactly one `rx_rdy_clr` pulse; next cycle `rd_valid`=1, `rd_data`=0xA5, `count`=1; pop → `count`=0.
- Held `rdy`: `rx_rdy` held high 1 extra cycle after ack (receiver model) → only one entry written, `count`=1.
- Fill and overrun (DEPTH=16): push 0x00..0x0F, then 0x10 → `count`=16, 0x10 dropped, `rx_rdy_clr` still pulses, `overrun`=1; drain yields 0x00..0x0F in order; `ovr_clr` → `overrun`=0.
- Simultaneous push+pop: when full, push 0x55 while popping → accepted, `count` stays 16, `overrun` stays 0; last drained byte is 0x55.
- Reset mid-operation: `count`=5, `rst_n` low for 1 cycle (asynchronous, between edges) → immediately `rd_valid`=0, `count`=0, `rx_rdy_clr`=0; next pushed byte 0x3C is the first read out.
- With UART_RX_FIFO_IRQ_EN, IRQ_THRESH=8: 8th push → `irq`=1 next cycle; 1 byte then no pushes for 255 cycles → `irq` asserts.
